// File: rtl/display_pkg.sv
// Shared definitions for the frame-synchronous display path: colours, scheduler
// state encoding and coordinate width.
package display_pkg;

    localparam int unsigned COORD_W = 12;

    localparam logic [23:0] RED    = 24'hFF0000;
    localparam logic [23:0] GREEN  = 24'h00FF00;
    localparam logic [23:0] BLUE   = 24'h0000FF;
    localparam logic [23:0] WHITE  = 24'hFFFFFF;
    localparam logic [23:0] BLACK  = 24'h000000;
    localparam logic [23:0] YELLOW = 24'hFFFF00;
    localparam logic [23:0] CYAN   = 24'h00FFFF;
    localparam logic [23:0] ROYAL  = 24'h4169E1;

    typedef enum logic [1:0] {
        StSplash  = 2'd0,
        StShow    = 2'd1,
        StPending = 2'd2,
        StBlank   = 2'd3
    } sched_state_e;

endpackage

// File: rtl/display_page_sched_if.sv
// Bundle of LCD coordinates, renderer pixels, keypad pulses and scheduler outputs.
// master = LCD driver / renderers / keypad side, slave = page scheduler.
interface display_page_sched_if #(
    parameter int unsigned N_SRC = 4
);
    import display_pkg::*;

    logic [COORD_W-1:0]  lcd_xpos;
    logic [COORD_W-1:0]  lcd_ypos;
    logic [24*N_SRC-1:0] src_data;
    logic                key_next;
    logic                key_prev;
    logic                key_home;
    logic [23:0]         lcd_data;
    logic [1:0]          page_sel;
    logic                busy;

    modport master (
        output lcd_xpos, lcd_ypos, src_data, key_next, key_prev, key_home,
        input  lcd_data, page_sel, busy
    );

    modport slave (
        input  lcd_xpos, lcd_ypos, src_data, key_next, key_prev, key_home,
        output lcd_data, page_sel, busy
    );

endinterface

// File: rtl/frame_tick_gen.sv
// One-cycle frame pulse on the first cycle the LCD coordinates reach the last pixel.
// Edge-detected so a driver dwelling on that pixel still yields a single tick.
module frame_tick_gen
    import display_pkg::*;
#(
    parameter int unsigned H_DISP = 640,
    parameter int unsigned V_DISP = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] xpos_i,
    input  logic [COORD_W-1:0] ypos_i,
    output logic               tick_o
);

    logic match_d;
    logic match_q;

    always_comb begin
        match_d = (xpos_i == COORD_W'(H_DISP - 1)) && (ypos_i == COORD_W'(V_DISP - 1));
        tick_o  = match_d & ~match_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

endmodule

// File: rtl/display_page_sched.sv
// Frame-synchronous page scheduler: splash page after reset, then keypad-selected
// pages that switch only at frame boundaries through an optional blank interval.
module display_page_sched
    import display_pkg::*;
#(
    parameter int unsigned H_DISP        = 640,
    parameter int unsigned V_DISP        = 480,
    parameter int unsigned N_SRC         = 4,
    parameter int unsigned SPLASH_FRAMES = 120,
    parameter int unsigned BLANK_FRAMES  = 2,
    parameter logic [23:0] BG_COLOR      = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    display_page_sched_if.slave  bus
);

    localparam logic [1:0] LastPage  = 2'(N_SRC - 1);
    localparam logic [7:0] SplashCnt = 8'(SPLASH_FRAMES);
    localparam logic [7:0] BlankCnt  = 8'(BLANK_FRAMES);

    sched_state_e state_d, state_q;
    logic [7:0]   cnt_d, cnt_q;
    logic [1:0]   page_d, page_q;
    logic [1:0]   target_d, target_q;
    logic [23:0]  lcd_data_d, lcd_data_q;
    logic [23:0]  src_pix;
    logic [7:0]   cnt_inc;
    logic         any_key;
    logic         frame_tick;

    // Page 0 is the splash page and is excluded from the key wrap range.
    function automatic logic [1:0] key_target(logic [1:0] from, logic nxt, logic prv,
                                              logic home);
        logic [1:0] res;
        res = from;
        if (home) begin
            res = 2'd1;
        end else if (nxt) begin
            res = (from == LastPage) ? 2'd1 : from + 2'd1;
        end else if (prv) begin
            res = (from <= 2'd1) ? LastPage : from - 2'd1;
        end
        return res;
    endfunction

    frame_tick_gen #(
        .H_DISP (H_DISP),
        .V_DISP (V_DISP)
    ) u_frame_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .xpos_i (bus.lcd_xpos),
        .ypos_i (bus.lcd_ypos),
        .tick_o (frame_tick)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        page_d   = page_q;
        target_d = target_q;
        any_key  = bus.key_next | bus.key_prev | bus.key_home;
        cnt_inc  = cnt_q + 8'd1;

        unique case (state_q)
            StSplash: begin
                if (frame_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == SplashCnt) begin
                        page_d  = 2'd1;
                        state_d = StShow;
                        cnt_d   = 8'd0;
                    end
                end
            end
            StShow: begin
                if (any_key) begin
                    target_d = key_target(page_q, bus.key_next, bus.key_prev, bus.key_home);
                    state_d  = StPending;
                    cnt_d    = 8'd0;
                end
            end
            StPending: begin
                // A key coinciding with the tick still lands before the switch.
                if (any_key) begin
                    target_d = key_target(target_q, bus.key_next, bus.key_prev, bus.key_home);
                end
                if (frame_tick) begin
                    cnt_d = 8'd0;
                    if (BLANK_FRAMES > 0) begin
                        state_d = StBlank;
                    end else begin
                        page_d  = target_d;
                        state_d = StShow;
                    end
                end
            end
            StBlank: begin
                if (any_key) begin
                    target_d = key_target(target_q, bus.key_next, bus.key_prev, bus.key_home);
                end
                if (frame_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == BlankCnt) begin
                        page_d  = target_d;
                        state_d = StShow;
                        cnt_d   = 8'd0;
                    end
                end
            end
            default: begin
                state_d = StSplash;
            end
        endcase
    end

    always_comb begin
        src_pix = 24'h0;
        for (int k = 0; k < N_SRC; k++) begin
            if (page_q == 2'(k)) begin
                src_pix = bus.src_data[24*k +: 24];
            end
        end
        lcd_data_d = (state_q == StBlank) ? BG_COLOR : src_pix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StSplash;
            cnt_q      <= 8'd0;
            page_q     <= 2'd0;
            target_q   <= 2'd0;
            lcd_data_q <= 24'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            page_q     <= page_d;
            target_q   <= target_d;
            lcd_data_q <= lcd_data_d;
        end
    end

    assign bus.lcd_data = lcd_data_q;
    assign bus.page_sel = page_q;
    assign bus.busy     = (state_q != StShow);

endmodule

// File: tb/tb_display_page_sched.sv
// Scoreboard bench for display_page_sched: a frame-level reference model queues the
// expected outputs of every clock; a monitor pops and compares them on the falling edge.
module tb_display_page_sched;

    localparam int          H    = 8;
    localparam int          V    = 4;
    localparam int          N    = 4;
    localparam int          SF   = 3;
    localparam int          BF   = 1;
    localparam logic [23:0] BG   = 24'hFFFFFF;

    localparam int M_SPLASH  = 0;
    localparam int M_SHOW    = 1;
    localparam int M_PENDING = 2;
    localparam int M_BLANK   = 3;

    typedef struct packed {
        logic [23:0] lcd;
        logic [1:0]  page;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    display_page_sched_if #(.N_SRC(N)) bus ();

    display_page_sched #(
        .H_DISP        (H),
        .V_DISP        (V),
        .N_SRC         (N),
        .SPLASH_FRAMES (SF),
        .BLANK_FRAMES  (BF),
        .BG_COLOR      (BG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.src_data = {24'h333333, 24'h222222, 24'h111111, 24'h000000};

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: what the display should be doing, in frame terms.
    int          m_state;
    int          m_page;
    int          m_target;
    int          m_frames;
    bit          m_prev_match;
    logic [23:0] m_lcd;

    // Inputs currently applied to the DUT (sampled at the next rising edge).
    int ax, ay;
    bit ak_n, ak_p, ak_h, arst;
    int hold_left = 0;
    bit hold_req  = 0;

    function automatic int key_dest(int from, bit kn, bit kp, bit kh);
        if (kh) return 1;
        if (kn) return (from % (N - 1)) + 1;
        if (kp) return ((from + N - 3) % (N - 1)) + 1;
        return from;
    endfunction

    task automatic model_reset();
        m_state      = M_SPLASH;
        m_page       = 0;
        m_target     = 0;
        m_frames     = 0;
        m_prev_match = 0;
        m_lcd        = 24'h0;
    endtask

    task automatic model_edge();
        bit match, tick, anykey;
        if (!arst) begin
            model_reset();
            return;
        end
        match        = (ax == H - 1) && (ay == V - 1);
        tick         = match && !m_prev_match;
        m_prev_match = match;
        anykey       = ak_n | ak_p | ak_h;
        m_lcd        = (m_state == M_BLANK) ? BG : 24'(m_page * 24'h111111);
        if (m_state == M_SPLASH) begin
            if (tick) m_frames++;
            if (m_frames == SF) begin
                m_page = 1; m_state = M_SHOW; m_frames = 0;
            end
        end else if (m_state == M_SHOW) begin
            if (anykey) begin
                m_target = key_dest(m_page, ak_n, ak_p, ak_h);
                m_state  = M_PENDING;
            end
        end else begin
            if (anykey) m_target = key_dest(m_target, ak_n, ak_p, ak_h);
            if (tick) begin
                if (m_state == M_PENDING && BF > 0) begin
                    m_state = M_BLANK; m_frames = 0;
                end else begin
                    if (m_state == M_BLANK) m_frames++;
                    if (m_state == M_PENDING || m_frames == BF) begin
                        m_page = m_target; m_state = M_SHOW; m_frames = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit kn, input bit kp, input bit kh, input bit r);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        if (hold_left > 0) begin
            hold_left--;
        end else begin
            ax++;
            if (ax == H) begin
                ax = 0;
                ay = (ay + 1) % V;
            end
            if (hold_req && ax == H - 1 && ay == V - 1) begin
                hold_left = 4;
                hold_req  = 0;
            end
        end
        ak_n = kn; ak_p = kp; ak_h = kh; arst = r;
        bus.lcd_xpos = 12'(ax);
        bus.lcd_ypos = 12'(ay);
        bus.key_next = kn;
        bus.key_prev = kp;
        bus.key_home = kh;
        rst_n        = r;
        if (!r) model_reset();
        e.lcd  = m_lcd;
        e.page = 2'(m_page);
        e.busy = (m_state != M_SHOW);
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [31:0] got,
                             input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic wait_state(input int s, input int budget);
        int n = 0;
        while (m_state != s && n < budget) begin
            step(0, 0, 0, 1);
            n++;
        end
        check_now("wait_state", 32'(m_state), 32'(s));
    endtask

    // Issue a key combination from SHOW and wait for the new page to appear.
    task automatic go(input bit kn, input bit kp, input bit kh, input int req_page);
        wait_state(M_SHOW, 400);
        step(kn, kp, kh, 1);
        step(0, 0, 0, 1);
        check_now("busy_after_key", 32'(bus.busy), 32'd1);
        wait_state(M_SHOW, 400);
        check_now("page_after_switch", 32'(bus.page_sel), 32'(req_page));
        step(0, 0, 0, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (bus.lcd_data !== e.lcd || bus.page_sel !== e.page || bus.busy !== e.busy) begin
                    bad++;
                    $display("FAIL out @%0t: got lcd=%h page=%0d busy=%0b required lcd=%h page=%0d busy=%0b",
                             $time, bus.lcd_data, bus.page_sel, bus.busy, e.lcd, e.page, e.busy);
                end
            end
        end
    end

    initial begin : stimulus
        int r;
        model_reset();
        ax = 0; ay = 0; ak_n = 0; ak_p = 0; ak_h = 0; arst = 0;
        rst_n = 1'b0;
        bus.lcd_xpos = '0;
        bus.lcd_ypos = '0;
        bus.key_next = 1'b0;
        bus.key_prev = 1'b0;
        bus.key_home = 1'b0;

        repeat (3) step(0, 0, 0, 0);
        check_now("reset_lcd", 32'(bus.lcd_data), 32'h0);
        check_now("reset_page", 32'(bus.page_sel), 32'd0);
        check_now("reset_busy", 32'(bus.busy), 32'd1);

        // Dwell on the last pixel in the first splash frame: must count as one frame.
        hold_req = 1;
        step(0, 0, 0, 1);
        wait_state(M_SHOW, 400);
        check_now("splash_done_page", 32'(bus.page_sel), 32'd1);
        check_now("splash_done_busy", 32'(bus.busy), 32'd0);
        step(0, 0, 0, 1);
        check_now("splash_done_lcd", 32'(bus.lcd_data), 32'h111111);

        go(1, 0, 0, 2);
        go(1, 0, 0, 3);
        go(1, 0, 0, 1);
        go(0, 1, 0, 3);
        go(1, 0, 0, 1);
        go(1, 1, 0, 2);
        go(1, 0, 1, 1);

        // Second next during blank retargets from the pending target.
        wait_state(M_SHOW, 400);
        step(1, 0, 0, 1);
        wait_state(M_BLANK, 400);
        step(1, 0, 0, 1);
        wait_state(M_SHOW, 400);
        check_now("double_next_page", 32'(bus.page_sel), 32'd3);

        // Asynchronous reset in the middle of a blank interval.
        wait_state(M_SHOW, 400);
        step(0, 0, 1, 1);
        wait_state(M_BLANK, 400);
        repeat (3) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        #1;
        check_now("midrst_lcd", 32'(bus.lcd_data), 32'h0);
        check_now("midrst_page", 32'(bus.page_sel), 32'd0);
        check_now("midrst_busy", 32'(bus.busy), 32'd1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        wait_state(M_SHOW, 400);
        check_now("resplash_page", 32'(bus.page_sel), 32'd1);

        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 59);
            if ($urandom_range(0, 199) == 0) hold_req = 1;
            step(r == 0 || r == 3 || r == 4, r == 1 || r == 3 || r == 4, r == 2 || r == 4, 1);
        end

        repeat (3) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
